// File: rtl/alu_multicycle.sv
// Registered funct-coded ALU with iterative shift-add MULTU into HI/LO.
// Single-cycle ops complete with a one-cycle done pulse; MULTU holds busy for WIDTH cycles.
module alu_multicycle #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = SHW + 1;

  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_MULT = 6'd25;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]   hi, hi_n, lo, lo_n;
  logic [WIDTH-1:0]   mcand, mcand_n, mplier, mplier_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]      count, count_n;
  logic [WIDTH-1:0]   out_n;
  logic               zero_n, ovf_n, busy_n, done_n;

  logic [WIDTH-1:0]   sum, dif, res;
  logic [WIDTH:0]     sdif, upper;
  logic [2*WIDTH-1:0] acc_step;
  logic               ovf_op;

  assign sum  = dataA + dataB;
  assign dif  = dataA - dataB;
  // One extra bit keeps the signed compare right even when a-b overflows
  assign sdif = {dataA[WIDTH-1], dataA} - {dataB[WIDTH-1], dataB};

  assign upper    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mplier[0] ? mcand : '0)};
  assign acc_step = {upper, acc[WIDTH-1:1]};

  always_comb begin
    res    = '0;
    ovf_op = 1'b0;
    case (Signal)
      F_AND:  res = dataA & dataB;
      F_OR:   res = dataA | dataB;
      F_ADD: begin
        res    = sum;
        ovf_op = (dataA[WIDTH-1] == dataB[WIDTH-1])
               & (sum[WIDTH-1] != dataA[WIDTH-1]);
      end
      F_SUB: begin
        res    = dif;
        ovf_op = (dataA[WIDTH-1] != dataB[WIDTH-1])
               & (dif[WIDTH-1] != dataA[WIDTH-1]);
      end
      F_SLT:  res = {{(WIDTH-1){1'b0}}, sdif[WIDTH]};
      F_SRL:  res = dataA >> dataB[SHW-1:0];
      F_MFHI: res = hi;
      F_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    hi_n     = hi;
    lo_n     = lo;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    count_n  = count;
    out_n    = dataOut;
    zero_n   = zero;
    ovf_n    = overflow;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (Signal == F_MULT) begin
            mcand_n  = dataA;
            mplier_n = dataB;
            acc_n    = '0;
            count_n  = CW'(WIDTH);
            state_n  = MUL;
          end else begin
            out_n  = res;
            zero_n = (res == '0);
            ovf_n  = ovf_op;
            done_n = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n    = acc_step;
        mplier_n = mplier >> 1;
        count_n  = count - 1'b1;
        if (count == CW'(1)) begin
          hi_n    = acc_step[2*WIDTH-1:WIDTH];
          lo_n    = acc_step[WIDTH-1:0];
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == MUL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      dataOut  <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      hi       <= hi_n;
      lo       <= lo_n;
      mcand    <= mcand_n;
      mplier   <= mplier_n;
      acc      <= acc_n;
      count    <= count_n;
      dataOut  <= out_n;
      zero     <= zero_n;
      overflow <= ovf_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_multicycle;

  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_MULT = 6'd25;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  sig;
  logic [31:0] a, b, dout;
  logic        zero, ovf, busy, done;

  logic        start8;
  logic [5:0]  sig8;
  logic [7:0]  a8, b8, dout8;
  logic        zero8, ovf8, busy8, done8;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Signal(sig),
    .dataA(a), .dataB(b), .dataOut(dout), .zero(zero),
    .overflow(ovf), .busy(busy), .done(done)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .Signal(sig8),
    .dataA(a8), .dataB(b8), .dataOut(dout8), .zero(zero8),
    .overflow(ovf8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [5:0] s, input logic [31:0] x,
                    input logic [31:0] y);
    start = 1'b1;
    sig   = s;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
  endtask

  task automatic op8(input logic [5:0] s, input logic [7:0] x,
                     input logic [7:0] y);
    start8 = 1'b1;
    sig8   = s;
    a8     = x;
    b8     = y;
    step();
    start8 = 1'b0;
  endtask

  task automatic wait_busy();
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sig = '0; a = '0; b = '0;
    start8 = 1'b0; sig8 = '0; a8 = '0; b8 = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out", dout, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    op(F_ADD, 32'h7FFFFFFF, 32'h1);
    chk("add_out", dout, 32'h80000000);
    chk("add_ovf", ovf, 1);
    chk("add_zero", zero, 0);
    chk("add_done", done, 1);
    chk("add_busy", busy, 0);
    step();
    chk("add_done_pulse", done, 0);
    chk("add_hold", dout, 32'h80000000);

    op(F_SUB, 32'd5, 32'd5);
    chk("sub_out", dout, 0);
    chk("sub_zero", zero, 1);
    chk("sub_ovf", ovf, 0);
    op(F_SUB, 32'h80000000, 32'h1);
    chk("sub_ovf2", ovf, 1);
    op(F_SLT, 32'hFFFFFFFF, 32'h1);
    chk("slt_neg", dout, 1);
    chk("slt_ovf_clr", ovf, 0);
    op(F_SLT, 32'h80000000, 32'h7FFFFFFF);
    chk("slt_ovfcase", dout, 1);
    op(F_SLT, 32'h7FFFFFFF, 32'h80000000);
    chk("slt_false", dout, 0);
    chk("slt_zero", zero, 1);

    op(F_SRL, 32'h80000000, 32'h24);
    chk("srl", dout, 32'h08000000);
    op(F_OR, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("or", dout, 32'hFFF0FFF0);
    op(6'd63, 32'h1234, 32'h5678);
    chk("undef", dout, 0);
    chk("undef_zero", zero, 1);
    op(F_AND, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("and", dout, 32'h00F000F0);
    chk("and_zero", zero, 0);

    op(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_busy_first", busy, 1);
    chk("mul_done_low", done, 0);
    wait_busy();
    chk("mul_busy_cycles", n, 32);
    chk("mul_done", done, 1);
    chk("mul_keep_out", dout, 32'h00F000F0);
    chk("mul_keep_zero", zero, 0);
    op(F_MFHI, 32'h0, 32'h0);
    chk("mfhi", dout, 32'hFFFFFFFE);
    op(F_MFLO, 32'h0, 32'h0);
    chk("mflo", dout, 32'h1);

    op(F_MULT, 32'd3, 32'd7);
    op(F_ADD, 32'd1, 32'd1);
    chk("ign_out", dout, 32'h1);
    chk("ign_done", done, 0);
    wait_busy();
    chk("hs_busy_cycles", n, 31);
    chk("hs_done", done, 1);
    op(F_MFLO, 32'h0, 32'h0);
    chk("b2b_mflo", dout, 32'd21);
    chk("b2b_done", done, 1);
    op(F_MFHI, 32'h0, 32'h0);
    chk("hs_mfhi", dout, 0);

    op(F_MULT, 32'd5, 32'd5);
    for (int i = 0; i < 8; i++) step();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    sig   = F_ADD;
    a     = 32'd9;
    b     = 32'd9;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", dout, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    op(F_MFLO, 32'h0, 32'h0);
    chk("abort_mflo", dout, 0);

    op8(F_MULT, 8'hFF, 8'hFF);
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      step();
    end
    chk("w8_busy_cycles", n, 8);
    chk("w8_done", done8, 1);
    op8(F_MFHI, 8'h0, 8'h0);
    chk("w8_mfhi", dout8, 8'hFE);
    op8(F_MFLO, 8'h0, 8'h0);
    chk("w8_mflo", dout8, 8'h01);
    op8(F_ADD, 8'h7F, 8'h01);
    chk("w8_add", dout8, 8'h80);
    chk("w8_ovf", ovf8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the 32-bit ripple ALU. Executes the same funct-coded AND/OR/ADD/SUB/SLT set plus SRL, MFHI and MFLO in one cycle. Adds an iterative unsigned multiply (MULTU) into internal HI/LO registers. Sits in the EX stage of the multicycle datapath and is driven by the control unit through a start/busy/done handshake.

## Interface

**Parameters**
- WIDTH, 32, datapath width in bits; ≥ 4, power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

**Ports**
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- start  in  1  launch operation; sampled only in IDLE.
- Signal  in  6  funct code: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, MULTU=25, MFHI=16, MFLO=18.
- dataA  in  WIDTH  operand A (rs).
- dataB  in  WIDTH  operand B (rt).
- dataOut  out  WIDTH  registered result; held until next single-cycle op.
- zero  out  1  registered; 1 when last written dataOut == 0.
- overflow  out  1  registered signed overflow of last ADD/SUB.
- busy  out  1  high while MULTU iterates.
- done  out  1  one-cycle pulse on operation completion.

## Operation

- **Reset values:** dataOut=0, zero=0, overflow=0, busy=0, done=0; HI=0, LO=0; state IDLE; counter=0.
- **States:** IDLE, MUL.
- **IDLE, start=1, Signal ≠ MULTU:** single-cycle op. Result registered at that edge.
  - AND, OR: bitwise.
  - ADD: dataA+dataB mod 2^WIDTH. overflow=1 iff operand signs equal and result sign differs.
  - SUB: dataA−dataB mod 2^WIDTH. overflow=1 iff operand signs differ and result sign ≠ sign of dataA.
  - SLT: dataOut=1 iff signed dataA < signed dataB, else 0. Computed from a (WIDTH+1)-bit sign-extended difference, so it is correct under overflow.
  - SRL: dataA >> dataB[SHW-1:0], logical, zero fill.
  - MFHI / MFLO: dataOut=HI / LO.
  - Undefined Signal: dataOut=0.
  - Ops other than ADD/SUB write overflow=0.
  - zero updated from the new dataOut.
  - done=1 next cycle. Stays IDLE.
- **IDLE, start=1, Signal = MULTU:** latch multiplicand=dataA and multiplier=dataB. Clear the 2·WIDTH accumulator. counter=WIDTH. Go to MUL.
- **MUL:** each cycle, perform one shift-add step: if multiplier LSB is 1, add multiplicand into the upper half of the accumulator (with carry), then shift right one bit. counter decrements.
  - When counter reaches 1, the final step writes HI=product[2W-1:W], LO=product[W-1:0], sets done=1 for the next cycle, and returns to IDLE.
  - MULTU leaves dataOut, zero and overflow unchanged.
- **Operand sampling:** operands are sampled only at accepted start. dataA/dataB/Signal may change freely afterwards.
- **start while busy:** ignored, not queued.
- **start in the done cycle:** accepted; back-to-back operation is legal.
- **reset mid-MULTU:** aborts; HI/LO=0, busy=0, no done pulse.
- **reset and start in the same cycle:** reset wins.

## Timing

- **Single-cycle op:** start at edge N. dataOut/zero/overflow valid and done=1 during cycle N+1. busy stays 0.
- **MULTU:** start at edge N. busy=1 during cycles N+1 … N+WIDTH. done=1 and HI/LO valid during cycle N+WIDTH+1, with busy=0.
  - Earliest MFHI result: cycle N+WIDTH+2.
- **Throughput:**
  - Single-cycle ops: one per clock.
  - MULTU: one per WIDTH+1 clocks.
- done is never asserted together with busy.
- All outputs are driven from registers; no combinational input-to-output path.

## Test plan

- **Reset then ADD:** ADD 0x7FFFFFFF + 0x00000001 → next cycle dataOut=0x80000000, overflow=1, zero=0, done=1 for exactly one cycle.
- **SUB and SLT:**
  - SUB 5−5 → dataOut=0, zero=1, overflow=0.
  - SLT 0xFFFFFFFF vs 0x00000001 → 1.
  - SLT 0x80000000 vs 0x7FFFFFFF → 1 (overflow case).
  - SLT 0x7FFFFFFF vs 0x80000000 → 0.
- **SRL and logic:**
  - SRL 0x80000000 by dataB=0x00000024 (low 5 bits = 4) → 0x08000000.
  - AND 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0.
  - OR of the same operands → 0xFFF0FFF0.
  - Undefined Signal=63 → 0.
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF.
  - busy high for 32 cycles; done in cycle 33.
  - Then MFHI → 0xFFFFFFFE and MFLO → 0x00000001.
  - dataOut unchanged across the multiply.
- **Handshake:**
  - start=ADD issued during busy is ignored; HI/LO correct for 3×7: HI=0, LO=21.
  - start in the done cycle is accepted; its result appears next cycle.
- **Reset mid-operation and WIDTH=8:**
  - reset at cycle 10 of MULTU → busy=0, no done; MFLO → 0.
  - WIDTH=8 build: MULTU 0xFF×0xFF → HI=0xFE, LO=0x01 after 8 busy cycles.
  - WIDTH=8 build: ADD 0x7F+0x01 → overflow=1.
